// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Constants and types shared by the fetch queue, decode and hazard logic.
//   NOP_INSTR : the word presented to decode when the queue is empty
//   FQ_DEPTH  : default queue depth (power of two, >= 2)
//   fq_entry_t: one stored entry, {pcplus4, instr}
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int          FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Fetch/decode side signals of the instruction queue.
//   master: fetch + decode side (drives enqF, instrF, pcplus4F, flushD, stallD)
//   slave : the queue (drives instrD, pcplus4D, validD, full, count, ovf)
interface fetch_queue_if #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH
) ();
  localparam int PTRW = $clog2(DEPTH);

  logic            enqF;
  logic [31:0]     instrF;
  logic [31:0]     pcplus4F;
  logic            flushD;
  logic            stallD;
  logic [31:0]     instrD;
  logic [31:0]     pcplus4D;
  logic            validD;
  logic            full;
  logic [PTRW:0]   count;
  logic            ovf;

  modport master (
    output enqF, instrF, pcplus4F, flushD, stallD,
    input  instrD, pcplus4D, validD, full, count, ovf
  );

  modport slave (
    input  enqF, instrF, pcplus4F, flushD, stallD,
    output instrD, pcplus4D, validD, full, count, ovf
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction queue between fetch and decode; replaces the IF/ID register.
//   Circular buffer of DEPTH {pcplus4, instr} entries. Redirects flush it.
//   Ports:
//     clk   - pipeline clock, rising edge
//     reset - asynchronous, active-low; clears pointers, count and ovf
//     q     - fetch_queue_if.slave (enqF/instrF/pcplus4F/flushD/stallD in,
//             instrD/pcplus4D/validD/full/count/ovf out)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);
  localparam int              PTRW    = $clog2(DEPTH);
  localparam int              CNTW    = PTRW + 1;
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

  fq_entry_t       r_mem [DEPTH];
  logic [PTRW-1:0] r_wp;
  logic [PTRW-1:0] r_rp;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;

  logic            w_full;
  logic            w_valid;
  logic            w_enq;
  logic            w_deq;
  fq_entry_t       w_head;

  assign w_full  = (r_cnt == CNT_MAX);
  assign w_valid = (r_cnt != '0);
  // A full queue refuses the write even if the head leaves this same cycle.
  assign w_enq   = q.enqF & ~w_full & ~q.flushD;
  assign w_deq   = w_valid & ~q.stallD & ~q.flushD;
  assign w_head  = r_mem[r_rp];

  // Storage needs no reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wp] <= '{pcplus4: q.pcplus4F, instr: q.instrF};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (q.flushD) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq) r_wp <= r_wp + PTR_ONE;
      if (w_deq) r_rp <= r_rp + PTR_ONE;
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky overflow: fetch ignored the full stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (q.enqF && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // Empty queue shows a nop; reset clears r_cnt asynchronously so the
  // outputs drop without waiting for a clock.
  assign q.instrD   = w_valid ? w_head.instr   : NOP_INSTR;
  assign q.pcplus4D = w_valid ? w_head.pcplus4 : 32'b0;
  assign q.validD   = w_valid;
  assign q.full     = w_full;
  assign q.count    = r_cnt;
  assign q.ovf      = r_ovf;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [63:0] sb [$];
  logic        m_ovf;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the queue against the model, then advance one clock with the
  // given inputs and update the model the way the edge should.
  task automatic step(input logic enq, input logic [31:0] ins, input logic [31:0] pc,
                      input logic stall, input logic flush);
    logic m_full;
    logic m_deq;
    logic m_enq;
    fq.enqF     = enq;
    fq.instrF   = ins;
    fq.pcplus4F = pc;
    fq.stallD   = stall;
    fq.flushD   = flush;
    #1;
    m_full = (sb.size() == DEPTH);
    chk("count",  32'(fq.count),  32'(sb.size()));
    chk("full",   32'(fq.full),   32'(m_full));
    chk("validD", 32'(fq.validD), 32'(sb.size() != 0));
    chk("ovf",    32'(fq.ovf),    32'(m_ovf));
    if (sb.size() != 0) begin
      chk("instrD",   fq.instrD,   sb[0][31:0]);
      chk("pcplus4D", fq.pcplus4D, sb[0][63:32]);
    end else begin
      chk("instrD_nop", fq.instrD,   NOP_INSTR);
      chk("pcplus4D_0", fq.pcplus4D, 32'h0);
    end
    if (enq && m_full) m_ovf = 1'b1;
    if (flush) begin
      sb.delete();
    end else begin
      m_deq = (sb.size() != 0) && !stall;
      m_enq = enq && !m_full;
      if (m_deq) void'(sb.pop_front());
      if (m_enq) sb.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    fq.enqF     = 1'b0;
    fq.instrF   = 32'h0;
    fq.pcplus4F = 32'h0;
    fq.stallD   = 1'b0;
    fq.flushD   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // reset state, idle
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // single pass-through: visible after one edge, drained on the next
    step(1'b1, 32'h20080005, 32'h4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // fill while stalled; fifth write overflows and is dropped
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1000 + 32'(i), 32'h8 + 32'(4 * i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // drain in order, one per cycle
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // refill; full with simultaneous enqueue and dequeue -> 3, write refused
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h2000 + 32'(i), 32'h40 + 32'(4 * i), 1'b1, 1'b0);
    step(1'b1, 32'hDEAD0001, 32'hBEEF0001, 1'b0, 1'b0);

    // count 3, flush with enqF: queue empties and the write is lost
    step(1'b1, 32'hDEAD0002, 32'hBEEF0002, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // enqueue right after a flush is accepted
    step(1'b1, 32'h3000, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h3001, 32'h84, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // count 2: async reset between edges clears outputs and ovf at once
    fq.enqF   = 1'b0;
    fq.stallD = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_count",    32'(fq.count),  32'h0);
    chk("rst_validD",   32'(fq.validD), 32'h0);
    chk("rst_instrD",   fq.instrD,      NOP_INSTR);
    chk("rst_pcplus4D", fq.pcplus4D,    32'h0);
    chk("rst_ovf",      32'(fq.ovf),    32'h0);
    chk("rst_full",     32'(fq.full),   32'h0);
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // queue restarts empty and works normally
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4000, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 32'h4001, 32'hC4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. It buffers up to DEPTH fetched instruction/PC+4 pairs so that i-cache hits are not lost while decode is stalled. It raises `full` to stall fetch and is emptied on every control-flow redirect. It replaces the plain IF/ID register: an empty queue behaves as a one-cycle pipeline register.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- PTRW, $clog2(DEPTH), pointer width (derived, not overridden)

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- enqF  in  1  fetch presents a valid instruction this cycle (cache hit, fetch not stalled)
- instrF  in  32  fetched instruction
- pcplus4F  in  32  PC+4 of fetched instruction
- flushD  in  1  redirect from decode (pcsrcD | jumpD); discard all contents
- stallD  in  1  decode cannot accept an instruction this cycle
- instrD  out  32  head instruction; 32'b0 (nop) when empty
- pcplus4D  out  32  head PC+4; 32'b0 when empty
- validD  out  1  head entry is valid (count ≠ 0)
- full  out  1  count == DEPTH; ORed into stallF by the fetch stage
- count  out  PTRW+1  current occupancy
- ovf  out  1  sticky: enqF asserted while full; cleared only by reset

## Operation
- Storage: circular buffer of DEPTH × 64 bits {pcplus4, instr}; write pointer `wp`, read pointer `rp`, occupancy `cnt`.
- Enqueue condition: enqF & !full & !flushD. Write at `wp`, then wp ← wp+1 mod DEPTH.
- Dequeue condition: validD & !stallD & !flushD. Then rp ← rp+1 mod DEPTH.
- cnt ← cnt + enq − deq. Simultaneous enqueue and dequeue leaves cnt unchanged.
- Full: no enqueue, even when a dequeue occurs in the same cycle. enqF & full sets `ovf`; data is dropped and storage is unchanged.
- Flush has priority over everything: wp, rp, cnt ← 0, and any enqueue or dequeue that cycle is discarded. Storage contents are not cleared.
- Outputs instrD/pcplus4D are a combinational read of entry `rp`, gated to 0 when cnt == 0.
- Reset: wp = rp = cnt = 0 and ovf = 0. Therefore instrD = 0, pcplus4D = 0, validD = 0, full = 0, count = 0. Storage is don't-care.
- Pointer arithmetic wraps naturally in PTRW bits. cnt is PTRW+1 bits so that DEPTH is representable.

## Timing
- Latency: an instruction enqueued at edge N is visible on instrD/validD after edge N (one cycle). There is no same-cycle bypass.
- full is derived from registered cnt. Fetch sees it in the same cycle, and an enqueue is blocked in that cycle.
- A dequeue at edge N exposes the next entry after edge N. Back-to-back dequeues sustain one per cycle.
- Flush asserted in cycle N: validD = 0 after edge N. An enqF in cycle N+1 is accepted normally.
- Reset deassertion mid-operation: the queue restarts empty. Reset assertion clears the outputs asynchronously, without waiting for clk.

## Structure
- One module, fetch_queue. Storage is a reg array inside it.
- A shared package or include holds NOP_INSTR (32'b0) and the default FQ_DEPTH, so that decode and hazard logic use the same constants.
- No sub-module is needed. If a second queue appears, factor out a generic `sync_fifo`.

## Test plan
- Reset low, then high with no enqF: count = 0, validD = 0, instrD = 0, full = 0.
- Enqueue 0x20080005/pc+4 0x4 with stallD = 0: after one edge validD = 1 and instrD = 0x20080005. On the next edge it is dequeued and count returns to 0.
- stallD = 1, enqueue 5 instructions: count = 4 and full = 1. The 5th sets ovf = 1 and is dropped. Releasing stallD drains all 4 in order over 4 cycles.
- Full queue with enqF and dequeue in the same cycle: count goes 4→3 and the enqueue is not accepted.
- count = 3 with flushD = 1, enqF = 1, stallD = 0: after the edge count = 0, validD = 0, and the enqueued word is absent.
- Pull reset low mid-stream with count = 2: outputs go to 0 immediately, before the next clk edge, and ovf clears.
